// File: rtl/bcd_pkg.sv
// Shared BCD display definitions: digit type, ASCII constants, streamer state.
package bcd_pkg;

  typedef struct packed {
    logic [3:0] value;
  } Digit;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_digits_ascii_streamer_if.sv
// Digit snapshot request plus valid/ready character stream toward the text renderer.
interface bcd_digits_ascii_streamer_if #(
  parameter int DIGITS_NUM = 6
) ();
  import bcd_pkg::*;

  logic                      start_in;
  Digit [DIGITS_NUM-1:0]     digits_in;
  logic                      overflow_in;
  logic [7:0]                char_out;
  logic                      char_valid_out;
  logic                      char_ready_in;
  logic                      char_last_out;
  logic                      busy_out;
  logic                      done_out;

  // Counter/sink side: supplies digits, start and ready; observes the stream.
  modport master (
    output start_in, digits_in, overflow_in, char_ready_in,
    input  char_out, char_valid_out, char_last_out, busy_out, done_out
  );

  // Streamer side.
  modport slave (
    input  start_in, digits_in, overflow_in, char_ready_in,
    output char_out, char_valid_out, char_last_out, busy_out, done_out
  );

endinterface

// File: rtl/bcd_digit_to_ascii.sv
// Single BCD digit to display character; overflow wins, then invalid BCD, then blanking.
module bcd_digit_to_ascii
  import bcd_pkg::*;
#(
  parameter logic [7:0] BLANK_CHAR = ASCII_SPACE
) (
  input  logic [3:0] value_i,
  input  logic       overflow_i,
  input  logic       blank_i,    // position may be blanked if it holds a zero
  output logic [7:0] char_o
);

  // Priority-ordered character selection.
  always_comb begin
    char_o = ASCII_ZERO + {4'h0, value_i};
    if (overflow_i)
      char_o = ASCII_DASH;
    else if (value_i > 4'd9)
      char_o = ASCII_QMARK;
    else if (blank_i && (value_i == 4'd0))
      char_o = BLANK_CHAR;
  end

endmodule

// File: rtl/bcd_digits_ascii_streamer.sv
// Snapshots a BCD count and streams it MSD-first as ASCII over valid/ready.
module bcd_digits_ascii_streamer
  import bcd_pkg::*;
#(
  parameter int         DIGITS_NUM         = 6,
  parameter bit         LEADING_ZERO_BLANK = 1'b1,
  parameter logic [7:0] BLANK_CHAR         = 8'h20
) (
  input logic                          clk_in,
  input logic                          reset_in,
  bcd_digits_ascii_streamer_if.slave   bus
);

  localparam int             IW      = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
  localparam logic [IW-1:0]  IDX_MAX = IW'(DIGITS_NUM - 1);

  state_t                 state_q;
  Digit [DIGITS_NUM-1:0]  snap_q;
  logic                   ovf_q;
  logic [IW-1:0]          idx_q;
  logic                   seen_nz_q;
  logic [7:0]             char_q;
  logic                   valid_q;
  logic                   last_q;
  logic                   busy_q;
  logic                   done_q;

  // Next character source: the live inputs when starting, else the snapshot at idx-1.
  logic [IW-1:0]  nidx_d;
  Digit           src_d;
  logic           src_ovf_d;
  logic           seen_nz_d;
  logic           blank_d;
  logic [7:0]     char_d;

  // Select the digit that will be presented next and its blanking context.
  always_comb begin
    nidx_d    = IDX_MAX;
    src_d     = bus.digits_in[IDX_MAX];
    src_ovf_d = bus.overflow_in;
    seen_nz_d = 1'b0;
    if (state_q == EMIT) begin
      nidx_d    = idx_q - 1'b1;
      src_d     = snap_q[nidx_d];
      src_ovf_d = ovf_q;
      // Digit being accepted now counts toward seen_nz (invalid codes are nonzero too).
      seen_nz_d = seen_nz_q | (snap_q[idx_q].value != 4'd0);
    end
    blank_d = LEADING_ZERO_BLANK && !seen_nz_d && (nidx_d != '0);
  end

  bcd_digit_to_ascii #(.BLANK_CHAR(BLANK_CHAR)) u_conv (
    .value_i    (src_d.value),
    .overflow_i (src_ovf_d),
    .blank_i    (blank_d),
    .char_o     (char_d)
  );

  // Control FSM with registered stream outputs; done pulses in the IDLE cycle after the last char.
  always_ff @(posedge clk_in) begin
    if (!reset_in) begin
      state_q   <= IDLE;
      snap_q    <= '0;
      ovf_q     <= 1'b0;
      idx_q     <= '0;
      seen_nz_q <= 1'b0;
      char_q    <= 8'h00;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_in) begin
            state_q   <= EMIT;
            snap_q    <= bus.digits_in;
            ovf_q     <= bus.overflow_in;
            idx_q     <= IDX_MAX;
            seen_nz_q <= 1'b0;
            char_q    <= char_d;
            valid_q   <= 1'b1;
            last_q    <= (IDX_MAX == '0);
            busy_q    <= 1'b1;
          end
        end
        EMIT: begin
          if (bus.char_ready_in) begin
            if (idx_q == '0) begin
              state_q <= IDLE;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q     <= nidx_d;
              seen_nz_q <= seen_nz_d;
              char_q    <= char_d;
              last_q    <= (nidx_d == '0);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.char_out       = char_q;
  assign bus.char_valid_out = valid_q;
  assign bus.char_last_out  = last_q;
  assign bus.busy_out       = busy_q;
  assign bus.done_out       = done_q;

endmodule
